sub_shift_block: RTL and testbench

Iterative AES SubBytes + ShiftRows stage that sits directly upstream of `mixed_column_block`. It accepts one 4x4 byte state over a valid/ready handshake and substitutes it through `SBOX_LANES` S-box instances, one lane group per cycle. It then presents the row-shifted result as a registered state. That result drives `input2mixedcolumn` unchanged.

---
 rtl/aes_pkg.sv | 46 ++++
 rtl/aes_sbox.sv | 12 +
 rtl/sub_shift_block.sv | 99 +++++++++
 tb/tb_sub_shift_block.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES types, FSM encodings and the FIPS-197 S-box table.
// Imported by the SubBytes/ShiftRows stage and the key expansion.
package aes_pkg;

   typedef logic [3:0][3:0][7:0] aes_state_t;

   localparam logic [7:0] ST_IDLE = 8'h00;
   localparam logic [7:0] ST_SUB  = 8'h01;
   localparam logic [7:0] ST_DONE = 8'h02;

   localparam logic [7:0] SBOX_TABLE [256] = '{
      8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5,
      8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
      8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0,
      8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
      8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc,
      8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
      8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a,
      8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
      8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0,
      8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
      8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b,
      8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
      8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85,
      8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
      8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5,
      8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
      8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17,
      8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
      8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88,
      8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
      8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c,
      8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
      8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9,
      8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
      8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6,
      8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
      8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e,
      8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
      8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94,
      8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
      8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68,
      8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
   };

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES S-box lookup, one byte in, one byte out.
// Shared by the SubBytes stage and the key expansion.
module aes_sbox
   import aes_pkg::*;
(
   input  logic [7:0] data,
   output logic [7:0] subst
);

   assign subst = SBOX_TABLE[data];

endmodule

// File: rtl/sub_shift_block.sv
// Iterative SubBytes over SBOX_LANES bytes per cycle, ShiftRows as wiring.
// Result feeds mixed_column_block.input2mixedcolumn.
module sub_shift_block
   import aes_pkg::*;
#(
   parameter int SBOX_LANES = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       in_valid,
   output logic       in_ready,
   input  aes_state_t state_in,
   output logic       out_valid,
   input  logic       out_ready,
   output aes_state_t state_out
);

   localparam int N  = 16 / SBOX_LANES;
   localparam int CW = (N > 1) ? $clog2(N) : 1;

   if (SBOX_LANES != 1 && SBOX_LANES != 2 && SBOX_LANES != 4 &&
       SBOX_LANES != 8 && SBOX_LANES != 16) begin : g_bad_lanes
      $error("sub_shift_block: SBOX_LANES must be 1, 2, 4, 8 or 16");
   end

   logic [7:0]       state;
   logic [CW-1:0]    cnt;
   aes_state_t       work;
   logic [15:0][7:0] work_flat;
   logic [15:0][7:0] work_nxt;
   logic [3:0]       idx [SBOX_LANES];
   logic [7:0]       sb  [SBOX_LANES];

   // flat byte k = r*4 + c maps onto the packed row/column layout
   assign work_flat = work;

   for (genvar l = 0; l < SBOX_LANES; l++) begin : g_lane
      assign idx[l] = 4'((int'(cnt) * SBOX_LANES) + l);
      aes_sbox u_sbox (
         .data  (work_flat[idx[l]]),
         .subst (sb[l])
      );
   end

   always_comb begin
      work_nxt = work_flat;
      for (int l = 0; l < SBOX_LANES; l++) begin
         work_nxt[idx[l]] = sb[l];
      end
   end

   assign out_valid = (state == ST_DONE);
   assign in_ready  = (state == ST_IDLE) || (out_valid && out_ready);

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_IDLE;
         cnt   <= '0;
         work  <= '0;
      end else begin
         unique case (state)
            ST_IDLE: begin
               if (in_valid) begin
                  work  <= state_in;
                  cnt   <= '0;
                  state <= ST_SUB;
               end
            end
            ST_SUB: begin
               work <= work_nxt;
               cnt  <= cnt + 1'b1;
               if (cnt == CW'(N - 1)) begin
                  state <= ST_DONE;
               end
            end
            ST_DONE: begin
               if (out_ready) begin
                  if (in_valid) begin
                     work  <= state_in;
                     cnt   <= '0;
                     state <= ST_SUB;
                  end else begin
                     state <= ST_IDLE;
                  end
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   // row r rotates left by r
   for (genvar r = 0; r < 4; r++) begin : g_row
      for (genvar c = 0; c < 4; c++) begin : g_col
         assign state_out[r][c] = work[r][(c + r) % 4];
      end
   end

endmodule

// File: tb/tb_sub_shift_block.sv
// Directed bench for sub_shift_block across all legal lane counts.
// Lane-4 instance carries the functional, backpressure and reset checks.
module tb_sub_shift_block;
   import aes_pkg::*;

   logic       clk;
   logic       rst;
   logic       in_valid;
   logic       out_ready;
   aes_state_t state_in;
   logic       rdy [5];
   logic       vld [5];
   aes_state_t so  [5];

   int n_chk;
   int n_fail;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   for (genvar i = 0; i < 5; i++) begin : g_dut
      sub_shift_block #(.SBOX_LANES(1 << i)) u_dut (
         .clk       (clk),
         .rst       (rst),
         .in_valid  (in_valid),
         .in_ready  (rdy[i]),
         .state_in  (state_in),
         .out_valid (vld[i]),
         .out_ready (out_ready),
         .state_out (so[i])
      );
   end

   typedef struct {
      string      name;
      aes_state_t din;
      aes_state_t dexp;
   } vec_t;

   function automatic aes_state_t mk(input logic [31:0] r0, input logic [31:0] r1,
                                     input logic [31:0] r2, input logic [31:0] r3);
      aes_state_t s;
      logic [31:0] rows [4];
      rows[0] = r0; rows[1] = r1; rows[2] = r2; rows[3] = r3;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            s[r][c] = rows[r][31-8*c -: 8];
      return s;
   endfunction

   function automatic logic [7:0] xt(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
      n_chk++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, req);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic run_vec(input vec_t v);
      int lat;
      state_in  = v.din;
      in_valid  = 1'b1;
      out_ready = 1'b1;
      step();
      in_valid = 1'b0;
      state_in = '1;
      chk({v.name, " in_ready low in SUB"}, 128'(rdy[2]), 128'(0));
      lat = 0;
      while (!vld[2] && lat < 40) begin
         step();
         lat++;
      end
      chk({v.name, " latency"}, 128'(lat), 128'(4));
      chk({v.name, " state_out"}, so[2], v.dexp);
      step();
      chk({v.name, " out_valid drops"}, 128'(vld[2]), 128'(0));
   endtask

   aes_state_t fips_in, fips_out, all63;
   vec_t       vecs [4];

   initial begin
      int lat, hi;
      int first [5];
      int second[5];
      logic prev [5];
      aes_state_t outs [5];
      logic [7:0] m0, m1, m2, m3;

      n_chk = 0;
      n_fail = 0;
      fips_in  = mk(32'h19a09ae9, 32'h3df4c6f8, 32'he3e28d48, 32'hbe2b2a08);
      fips_out = mk(32'hd4e0b81e, 32'hbfb44127, 32'h5d521198, 32'h30aef1e5);
      all63    = mk(32'h63636363, 32'h63636363, 32'h63636363, 32'h63636363);
      vecs[0] = '{"zero", '0, all63};
      vecs[1] = '{"fips", fips_in, fips_out};
      vecs[2] = '{"spot", mk(32'h53000000, 32'h00ff0000, 32'h00000100, 32'h00000000),
                  mk(32'hed636363, 32'h16636363, 32'h7c636363, 32'h63636363)};
      vecs[3] = '{"ones", '1, mk(32'h16161616, 32'h16161616, 32'h16161616, 32'h16161616)};

      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; state_in = '0;
      step();
      chk("reset in_ready", 128'(rdy[2]), 128'(1));
      chk("reset out_valid", 128'(vld[2]), 128'(0));
      chk("reset state_out", so[2], '0);
      rst = 1'b0;
      step();

      for (int i = 0; i < 4; i++) run_vec(vecs[i]);

      // backpressure with a second state waiting
      state_in = fips_in; in_valid = 1'b1; out_ready = 1'b0;
      step();
      in_valid = 1'b0;
      lat = 0;
      while (!vld[2] && lat < 40) begin step(); lat++; end
      chk("bp first latency", 128'(lat), 128'(4));
      state_in = '0; in_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("bp out_valid held", 128'(vld[2]), 128'(1));
         chk("bp in_ready low", 128'(rdy[2]), 128'(0));
         chk("bp state_out held", so[2], fips_out);
      end
      m0 = xt(so[2][0][0]) ^ xt(so[2][1][0]) ^ so[2][1][0] ^ so[2][2][0] ^ so[2][3][0];
      m1 = so[2][0][0] ^ xt(so[2][1][0]) ^ xt(so[2][2][0]) ^ so[2][2][0] ^ so[2][3][0];
      m2 = so[2][0][0] ^ so[2][1][0] ^ xt(so[2][2][0]) ^ xt(so[2][3][0]) ^ so[2][3][0];
      m3 = xt(so[2][0][0]) ^ so[2][0][0] ^ so[2][1][0] ^ so[2][2][0] ^ xt(so[2][3][0]);
      chk("mixcolumn col0", 128'({m0, m1, m2, m3}), 128'(32'h046681e5));
      out_ready = 1'b1;
      #1;
      chk("bp in_ready follows out_ready", 128'(rdy[2]), 128'(1));
      step();
      in_valid = 1'b0; state_in = fips_in;
      lat = 0;
      while (!vld[2] && lat < 40) begin step(); lat++; end
      chk("bp second latency", 128'(lat), 128'(4));
      chk("bp second state_out", so[2], all63);
      step();

      // reset in the middle of SUB
      state_in = fips_in; in_valid = 1'b1; out_ready = 1'b1;
      step();
      in_valid = 1'b0;
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("midrst in_ready", 128'(rdy[2]), 128'(1));
      chk("midrst out_valid", 128'(vld[2]), 128'(0));
      chk("midrst state_out", so[2], '0);
      hi = 0;
      for (int i = 0; i < 8; i++) begin
         step();
         if (vld[2]) hi++;
      end
      chk("midrst no out_valid", 128'(hi), 128'(0));

      // lane sweep, inputs held valid and outputs always accepted
      rst = 1'b1;
      step();
      rst = 1'b0;
      state_in = fips_in; in_valid = 1'b1; out_ready = 1'b1;
      step();
      for (int d = 0; d < 5; d++) begin
         first[d] = -1; second[d] = -1; prev[d] = 1'b0; outs[d] = '0;
      end
      for (int t = 1; t <= 40; t++) begin
         step();
         for (int d = 0; d < 5; d++) begin
            if (vld[d] && !prev[d]) begin
               if (first[d] < 0) begin
                  first[d] = t;
                  outs[d] = so[d];
               end else if (second[d] < 0) begin
                  second[d] = t;
               end
            end
            prev[d] = vld[d];
         end
      end
      in_valid = 1'b0;
      for (int d = 0; d < 5; d++) begin
         chk($sformatf("sweep L%0d latency", 1 << d), 128'(first[d]), 128'(16 >> d));
         chk($sformatf("sweep L%0d period", 1 << d), 128'(second[d] - first[d]),
             128'((16 >> d) + 1));
         chk($sformatf("sweep L%0d state_out", 1 << d), outs[d], fips_out);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
